tm1638_display_scheduler: RTL
=============================

Name: tm1638_display_scheduler

Overview:
- Sequences the TM1638 command stream for one display board.
- Holds a 16-entry shadow copy of the display registers and tracks which entries are dirty.
- After reset it issues the mandatory init commands, then emits 18-bit command words over a valid/ready handshake to the downstream serial driver. Each word carries only changed registers, plus control (brightness/show) updates and periodic full refreshes.
- Sits between application logic and the TM1638 bit-level serialiser.

Parameters:
REFRESH_CYCLES, 0, clocks between forced full refreshes (all 16 entries marked dirty); 0 disables.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  write strobe into the shadow register file
wr_reg  in  4  register index {grid[2:0], segment}; GRIDn_SEG07=2n, GRIDn_SEG89=2n+1
wr_data  in  8  segment data for wr_reg
brightness  in  3  requested brightness, 0..7
show  in  1  requested display on (1) / off (0)
cmd_valid  out  1  cmd_word valid
cmd_word  out  18  {dir[17], has_data[16], data[15:8], cmd_type[7:6], args[5:0]}
cmd_ready  in  1  downstream accepts cmd_word when cmd_valid&&cmd_ready
busy  out  1  init incomplete, a word outstanding, or any work pending

Behaviour:
- Reset (rst_n low, async):
  - Outputs: cmd_valid=0, cmd_word=0, busy=1.
  - State: shadow=all 0x00, dirty=16'hFFFF, ctrl_sent={show=0,brightness=0}, rr_ptr=15, refresh counter=0, state=INIT_DATA.
- Word encodings (dir always WRITE=0):
  - Data command: has_data=0, data=0, type=01, args={2'b00, mode=NORMAL 0, addr=FIXED 1, dir 0, 0}, giving 18'h00044.
  - Control command: has_data=0, data=0, type=10, args={2'b00, show, brightness}.
  - Address+data command: has_data=1, data=shadow[r], type=11, args={2'b00, r[3:0]}.
- FSM states: INIT_DATA, INIT_CTRL, IDLE, SEND.
  - INIT_DATA: cmd_valid=1, word=18'h00044 from the first clk after reset release. On handshake go to INIT_CTRL.
  - INIT_CTRL: word built from the current show/brightness. On handshake, ctrl_sent<=those values; go to IDLE.
  - IDLE: cmd_valid=0. Selection takes priority in this order:
    - ctrl_pending (show/brightness != ctrl_sent): load the control word.
    - otherwise, any dirty bit set: pick the first dirty index searching upward from rr_ptr+1, mod 16 wrap. Load its address word and set rr_ptr<=index.
    - Loading a word means the state is SEND on the next cycle.
  - SEND: cmd_valid=1. cmd_word and the register index are frozen until handshake.
    - On handshake: cmd_valid=0 next cycle, state IDLE.
    - For an address word, clear the dirty bit of the sent index, unless a same-index write occurs in the handshake cycle (then it stays set).
    - For a control word, ctrl_sent<=the sent values.
  - Throughput: at most one word per 2 clocks (IDLE→SEND→IDLE).
- Writes:
  - wr_en updates shadow[wr_reg] and sets dirty[wr_reg] every cycle, in any state, including init.
  - A write to the index in SEND does not alter the frozen cmd_word; the new data goes out on a later pass.
- Control changes:
  - Inputs are compared continuously.
  - A change back to ctrl_sent before selection cancels the pending update.
  - The words are never merged.
- Refresh (REFRESH_CYCLES>0):
  - The counter runs in IDLE/SEND and wraps at REFRESH_CYCLES-1.
  - On wrap, dirty<=16'hFFFF, OR'd with same-cycle clears; the set wins.
- busy = (state!=IDLE) || ctrl_pending || (dirty!=0).
- cmd_ready held low indefinitely: the word stays stable and valid; no loss.
- Reset mid-transfer: aborts immediately; after release the full init sequence reruns and all 16 registers are rewritten.

Decomposition:
- Shared package tm1638_types gets:
  - the word field offsets;
  - a DATA_CMD_INIT constant (18'h00044);
  - a state enum typedef;
  - a helper returning the next dirty index after a pointer (round-robin find-first).
- Command words are built only through the package's make_* functions.
- One sub-module is natural: tm1638_rr_pick, a combinational 16-bit round-robin find-first (dirty, rr_ptr → found, index).

Test Plan:
- Reset release, cmd_ready=1, show=1, brightness=7:
  - words 18'h00044, then 18'h0008F;
  - then 16 address words, index 0..15, data 0x00 (e.g. index 5 gives 18'h100C5);
  - then busy=0.
- After idle, write reg 5=0x3F → exactly one word, 18'h13FC5, busy falls after handshake.
- cmd_ready=0 for 20 clocks during SEND → cmd_valid and cmd_word stable; a write to the same index in that window → the old word completes, then a second word carries the new data.
- Writes to regs 0, 3 and 14 in one burst, with reg 0 rewritten every other cycle → order 0, 3, 14, 0 (round-robin, no starvation of 3 or 14).
- brightness 7→2 while dirty regs are pending → control word 18'h0008A issued before the next address word.
- REFRESH_CYCLES=64, no writes → 16 address words re-issued every 64 clocks; assert rst_n low mid-SEND → cmd_valid=0 immediately, init resequences from 18'h00044.

Source files
------------

// File: rtl/tm1638_types_pkg.sv
// ----------------------------------------------------------------------------
// tm1638_types
// Shared definitions for the TM1638 display scheduler:
//   - bit offsets of the 18-bit command word
//     {dir[17], has_data[16], data[15:8], cmd_type[7:6], args[5:0]}
//   - the fixed-address data command sent first after reset
//   - scheduler state encoding
//   - word builders (every command word is produced through make_*)
//   - round-robin find-first over the 16 dirty flags
// ----------------------------------------------------------------------------
package tm1638_types;

   localparam int WORD_W       = 18;
   localparam int DIR_BIT      = 17;
   localparam int HAS_DATA_BIT = 16;
   localparam int DATA_LSB     = 8;
   localparam int TYPE_LSB     = 6;
   localparam int ARGS_LSB     = 0;
   localparam int NUM_REGS     = 16;

   localparam logic [1:0] TYPE_DATA = 2'b01;
   localparam logic [1:0] TYPE_CTRL = 2'b10;
   localparam logic [1:0] TYPE_ADDR = 2'b11;

   // Write direction, normal mode, fixed addressing.
   localparam logic [WORD_W-1:0] DATA_CMD_INIT = 18'h00044;

   typedef enum logic [1:0] {
      ST_INIT_DATA,
      ST_INIT_CTRL,
      ST_IDLE,
      ST_SEND
   } state_e;

   typedef struct packed {
      logic       found;
      logic [3:0] index;
   } rr_pick_t;

   // Data command: args = {00, mode=normal(0), addr=fixed(1), dir=write(0), 0}.
   function automatic logic [WORD_W-1:0] make_data_cmd();
      logic [WORD_W-1:0] w;
      w = '0;
      w[TYPE_LSB +: 2] = TYPE_DATA;
      w[ARGS_LSB +: 6] = 6'b00_0_1_0_0;
      return w;
   endfunction

   // Display control: args = {00, show, brightness}.
   function automatic logic [WORD_W-1:0] make_ctrl_cmd(input logic       show,
                                                       input logic [2:0] brightness);
      logic [WORD_W-1:0] w;
      w = '0;
      w[TYPE_LSB +: 2] = TYPE_CTRL;
      w[ARGS_LSB +: 6] = {2'b00, show, brightness};
      return w;
   endfunction

   // Address set carrying one register's segment data.
   function automatic logic [WORD_W-1:0] make_addr_cmd(input logic [3:0] index,
                                                       input logic [7:0] data);
      logic [WORD_W-1:0] w;
      w = '0;
      w[HAS_DATA_BIT]    = 1'b1;
      w[DATA_LSB +: 8]   = data;
      w[TYPE_LSB +: 2]   = TYPE_ADDR;
      w[ARGS_LSB +: 6]   = {2'b00, index};
      return w;
   endfunction

   // First set bit searching upward from ptr+1, wrapping mod 16. The last
   // candidate (i=16) is ptr itself, so a lone dirty entry at ptr is found.
   function automatic rr_pick_t rr_next_dirty(input logic [NUM_REGS-1:0] dirty,
                                              input logic [3:0]          ptr);
      rr_pick_t   res;
      logic [3:0] cand;
      res = '0;
      for (int i = 1; i <= NUM_REGS; i++) begin
         cand = ptr + 4'(i);
         if (!res.found && dirty[cand]) begin
            res.found = 1'b1;
            res.index = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tm1638_rr_pick.sv
// ----------------------------------------------------------------------------
// tm1638_rr_pick
// Combinational 16-entry round-robin find-first.
//   dirty_i  : per-register dirty flags
//   ptr_i    : index of the register sent last
//   found_o  : at least one flag set
//   index_o  : first set flag after ptr_i (wrapping)
// ----------------------------------------------------------------------------
module tm1638_rr_pick
   import tm1638_types::*;
(
   input  logic [NUM_REGS-1:0] dirty_i,
   input  logic [3:0]          ptr_i,
   output logic                found_o,
   output logic [3:0]          index_o
);

   rr_pick_t pick;

   always_comb begin
      pick = rr_next_dirty(dirty_i, ptr_i);
   end

   assign found_o = pick.found;
   assign index_o = pick.index;

endmodule

// File: rtl/tm1638_display_scheduler.sv
// ----------------------------------------------------------------------------
// tm1638_display_scheduler
// Keeps a shadow of the 16 TM1638 display registers, tracks which ones have
// changed, and emits command words to the bit-level serialiser.
//   clk, rst_n              : clock, asynchronous active-low reset
//   wr_en/wr_reg/wr_data    : shadow register write port (any time)
//   brightness, show        : requested display control, compared continuously
//   cmd_valid/cmd_word      : command word out, held until cmd_ready
//   cmd_ready               : downstream accept
//   busy                    : init running, word outstanding or work pending
// REFRESH_CYCLES > 0 marks every register dirty once per that many clocks.
// ----------------------------------------------------------------------------
module tm1638_display_scheduler
   import tm1638_types::*;
#(
   parameter int REFRESH_CYCLES = 0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [3:0]        wr_reg,
   input  logic [7:0]        wr_data,
   input  logic [2:0]        brightness,
   input  logic              show,
   output logic              cmd_valid,
   output logic [WORD_W-1:0] cmd_word,
   input  logic              cmd_ready,
   output logic              busy
);

   state_e              state_q;
   logic                cmd_valid_q;
   logic [WORD_W-1:0]   cmd_word_q;
   logic [3:0]          ctrl_sent_q;      // {show, brightness} last accepted
   logic [3:0]          rr_ptr_q;
   logic [3:0]          send_idx_q;
   logic                send_is_addr_q;
   logic [NUM_REGS-1:0] dirty_q, dirty_d;
   logic                stale_q, stale_d; // sent index rewritten after its word was frozen
   logic [7:0]          shadow_q [NUM_REGS];

   logic       handshake;
   logic       ctrl_pending;
   logic       pick_found;
   logic [3:0] pick_index;
   logic       load_ctrl;
   logic       load_addr;
   logic       addr_done;
   logic       refresh_wrap;

   assign handshake    = cmd_valid_q && cmd_ready;
   assign ctrl_pending = ({show, brightness} != ctrl_sent_q);
   assign load_ctrl    = (state_q == ST_IDLE) && ctrl_pending;
   assign load_addr    = (state_q == ST_IDLE) && !ctrl_pending && pick_found;
   assign addr_done    = (state_q == ST_SEND) && handshake && send_is_addr_q;

   tm1638_rr_pick u_rr_pick (
      .dirty_i (dirty_q),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .index_o (pick_index)
   );

   // ------------------------------------------------------------------ refresh
   generate
      if (REFRESH_CYCLES > 0) begin : gen_refresh
         localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         logic [CW-1:0] refresh_cnt_q;
         logic          running;

         assign running      = (state_q == ST_IDLE) || (state_q == ST_SEND);
         assign refresh_wrap = running && (refresh_cnt_q == CW'(REFRESH_CYCLES - 1));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               refresh_cnt_q <= '0;
            end else if (running) begin
               refresh_cnt_q <= refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
            end
         end
      end else begin : gen_no_refresh
         assign refresh_wrap = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------ shadow regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= 8'h00;
         end
      end else if (wr_en) begin
         shadow_q[wr_reg] <= wr_data;
      end
   end

   // ------------------------------------------------------------ dirty flags
   // Order matters: the handshake clear is overridden by a write, and a
   // refresh overrides everything.
   always_comb begin
      dirty_d = dirty_q;
      if (addr_done && !stale_q) begin
         dirty_d[send_idx_q] = 1'b0;
      end
      if (wr_en) begin
         dirty_d[wr_reg] = 1'b1;
      end
      if (refresh_wrap) begin
         dirty_d = '1;
      end
   end

   // A write landing on the selected index in the load cycle, or at any time
   // while its word waits, must keep the entry dirty past the handshake.
   always_comb begin
      stale_d = stale_q;
      if (load_addr) begin
         stale_d = wr_en && (wr_reg == pick_index);
      end else if ((state_q == ST_SEND) && wr_en && (wr_reg == send_idx_q)) begin
         stale_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty_q <= '1;
         stale_q <= 1'b0;
      end else begin
         dirty_q <= dirty_d;
         stale_q <= stale_d;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_INIT_DATA;
         cmd_valid_q    <= 1'b0;
         cmd_word_q     <= '0;
         ctrl_sent_q    <= '0;
         rr_ptr_q       <= 4'hF;
         send_idx_q     <= '0;
         send_is_addr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT_DATA: begin
               if (!cmd_valid_q) begin
                  cmd_valid_q <= 1'b1;
                  cmd_word_q  <= make_data_cmd();
               end else if (cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= ST_INIT_CTRL;
               end
            end
            ST_INIT_CTRL: begin
               if (!cmd_valid_q) begin
                  cmd_valid_q    <= 1'b1;
                  cmd_word_q     <= make_ctrl_cmd(show, brightness);
                  send_is_addr_q <= 1'b0;
               end else if (cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  ctrl_sent_q <= cmd_word_q[ARGS_LSB +: 4];
                  state_q     <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (load_ctrl) begin
                  cmd_valid_q    <= 1'b1;
                  cmd_word_q     <= make_ctrl_cmd(show, brightness);
                  send_is_addr_q <= 1'b0;
                  state_q        <= ST_SEND;
               end else if (load_addr) begin
                  cmd_valid_q    <= 1'b1;
                  cmd_word_q     <= make_addr_cmd(pick_index, shadow_q[pick_index]);
                  send_is_addr_q <= 1'b1;
                  send_idx_q     <= pick_index;
                  rr_ptr_q       <= pick_index;
                  state_q        <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (handshake) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
                  if (!send_is_addr_q) begin
                     ctrl_sent_q <= cmd_word_q[ARGS_LSB +: 4];
                  end
               end
            end
            default: begin
               state_q <= ST_INIT_DATA;
            end
         endcase
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_word  = cmd_word_q;
   assign busy      = (state_q != ST_IDLE) || ctrl_pending || (dirty_q != '0);

endmodule
